// File: rtl/loader_pkg.sv
// Shared definitions for the operand loader: state encoding, select values, default width.
package loader_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    localparam logic [1:0] ST_LOAD_A = 2'b00;
    localparam logic [1:0] ST_LOAD_B = 2'b01;
    localparam logic [1:0] ST_READY  = 2'b10;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        StLoadA = ST_LOAD_A,
        StLoadB = ST_LOAD_B,
        StReady = ST_READY
    } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and rising-edge press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            pulse_q, pulse_d;

    // Counter runs only while the synced level disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        pulse_d = level_d & ~level_q;
    end

    // Synchronizer, debounce state and registered press pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/operand_loader.sv
// Captures operands A then B from the switches on LOAD presses and gates the adder enable.
module operand_loader
    import loader_pkg::*;
#(
    parameter int unsigned WIDTH           = DEFAULT_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_load,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             sel,
    output logic             add_en,
    output logic             load_ack,
    output logic [1:0]       state_led
);

    logic load_pulse, clear_pulse;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_load_db (
        .clk_i  (clk),
        .rst_i  (rst),
        .btn_i  (btn_load),
        .pulse_o(load_pulse)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear_db (
        .clk_i  (clk),
        .rst_i  (rst),
        .btn_i  (btn_clear),
        .pulse_o(clear_pulse)
    );

    state_e           state_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic             sel_q, add_en_q, load_ack_q;

    // Capture FSM; clear takes priority over load, all outputs registered with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StLoadA;
            op_a_q     <= '0;
            op_b_q     <= '0;
            sel_q      <= SEL_A;
            add_en_q   <= 1'b0;
            load_ack_q <= 1'b0;
        end else if (clear_pulse) begin
            state_q    <= StLoadA;
            op_a_q     <= '0;
            op_b_q     <= '0;
            sel_q      <= SEL_A;
            add_en_q   <= 1'b0;
            load_ack_q <= 1'b0;
        end else begin
            load_ack_q <= 1'b0;
            case (state_q)
                StLoadA, StReady: begin
                    if (load_pulse) begin
                        // A fresh A always restarts the computation, keeping old B.
                        op_a_q     <= sw;
                        load_ack_q <= 1'b1;
                        state_q    <= StLoadB;
                        sel_q      <= SEL_B;
                        add_en_q   <= 1'b0;
                    end
                end
                StLoadB: begin
                    if (load_pulse) begin
                        op_b_q     <= sw;
                        load_ack_q <= 1'b1;
                        state_q    <= StReady;
                        sel_q      <= SEL_A;
                        add_en_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= StLoadA;
                    sel_q    <= SEL_A;
                    add_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign sel       = sel_q;
    assign add_en    = add_en_q;
    assign load_ack  = load_ack_q;
    assign state_led = state_q;

endmodule
